// File: rtl/bcp_pkg.sv
// Shared types and widths for the BCP implication path: implication word layout
// and the read-side FSM states.
package bcp_pkg;

    localparam int FORMULA_MAX_VARIABLE = 20;
    localparam int VAR_ENC_LEN          = $clog2(FORMULA_MAX_VARIABLE + 1);
    localparam int IMPL_WIDTH           = VAR_ENC_LEN + 1;

    // Field order makes the value bit land at bit 0 of the packed word.
    typedef struct packed {
        logic [VAR_ENC_LEN-1:0] vidx;
        logic                   val;
    } impl_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        PRESENT = 2'd2
    } rd_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above the pointer,
// wrapping at N. The pointer register lives in the instantiating block.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]                     req_i,
    input  logic [((N > 1) ? $clog2(N) : 1)-1:0] ptr_i,
    output logic [N-1:0]                     gnt_o,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] idx_o,
    output logic                             any_o
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    int w_k;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        w_k   = 0;
        for (int off = 0; off < N; off++) begin
            w_k = (int'(ptr_i) + off) % N;
            if (!any_o && req_i[w_k]) begin
                any_o       = 1'b1;
                gnt_o[w_k]  = 1'b1;
                idx_o       = IW'(w_k);
            end
        end
    end

endmodule

// File: rtl/implication_queue_ctrl.sv
// Arbitrates clause-evaluator implications into the implication FIFO and presents
// popped entries downstream. Define IMPL_DEDUP_EN for pending-table dedup/conflict.
module implication_queue_ctrl
    import bcp_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         en_i,
    input  logic                         flush_i,
    input  logic [N_REQ-1:0]             req_valid_i,
    input  logic [N_REQ*IMPL_WIDTH-1:0]  req_impl_i,
    output logic [N_REQ-1:0]             req_ready_o,
    output logic                         fifo_wr_o,
    output logic [IMPL_WIDTH-1:0]        fifo_impl_o,
    input  logic                         fifo_full_i,
    input  logic                         fifo_empty_i,
    output logic                         fifo_rd_o,
    input  logic [IMPL_WIDTH-1:0]        fifo_impl_i,
    output logic                         fifo_rst_o,
    output logic                         impl_valid_o,
    output logic [IMPL_WIDTH-1:0]        impl_o,
    input  logic                         impl_ready_i,
    output logic                         conflict_o,
    output logic [VAR_ENC_LEN-1:0]       conflict_var_o,
    output logic                         busy_o
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PW-1:0]    r_rr_ptr;
    rd_state_t        r_state;
    logic             r_impl_valid;
    impl_t            r_impl;

    logic [N_REQ-1:0] w_req_elig;
    logic [N_REQ-1:0] w_gnt;
    logic [PW-1:0]    w_idx;
    logic             w_any;
    impl_t            w_sel;
    logic             w_can_grant;
    logic             w_dup;
    logic             w_opp;
    logic             w_conflict;
    logic             w_accept;
    logic             w_write;
    logic             w_rd;
    logic             w_hs;

    // Variable index 0 is reserved; such requests are never eligible and stall.
    always_comb begin
        w_req_elig = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_req_elig[k] = req_valid_i[k] &&
                            (req_impl_i[k*IMPL_WIDTH+1 +: VAR_ENC_LEN] != '0);
        end
    end

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req_i (w_req_elig),
        .ptr_i (r_rr_ptr),
        .gnt_o (w_gnt),
        .idx_o (w_idx),
        .any_o (w_any)
    );

    assign w_sel       = impl_t'(req_impl_i[int'(w_idx)*IMPL_WIDTH +: IMPL_WIDTH]);
    assign w_can_grant = rst_ni && en_i && !flush_i && !fifo_full_i && !w_conflict;
    assign w_accept    = w_can_grant && w_any && !w_opp;
    assign w_write     = w_accept && !w_dup;
    assign w_rd        = rst_ni && en_i && !flush_i && !fifo_empty_i && (r_state == IDLE);
    assign w_hs        = (r_state == PRESENT) && impl_ready_i;

    assign req_ready_o  = w_accept ? w_gnt : '0;
    assign fifo_wr_o    = w_write;
    assign fifo_impl_o  = w_write ? w_sel : '0;
    assign fifo_rd_o    = w_rd;
    assign fifo_rst_o   = rst_ni && flush_i;
    assign impl_valid_o = r_impl_valid;
    assign impl_o       = r_impl;
    assign busy_o       = rst_ni && (!fifo_empty_i || (r_state != IDLE) || (|req_valid_i));

`ifdef IMPL_DEDUP_EN
    logic [FORMULA_MAX_VARIABLE:0] r_pend_v;
    logic [FORMULA_MAX_VARIABLE:0] r_pend_val;
    logic                          r_conflict;
    logic [VAR_ENC_LEN-1:0]        r_conflict_var;
    logic                          w_in_range;

    always_comb begin
        w_in_range = (w_sel.vidx <= VAR_ENC_LEN'(FORMULA_MAX_VARIABLE));
        w_dup      = 1'b0;
        w_opp      = 1'b0;
        if (w_in_range && r_pend_v[w_sel.vidx]) begin
            w_dup = (r_pend_val[w_sel.vidx] == w_sel.val);
            w_opp = !w_dup;
        end
    end

    // A write that sets an entry takes priority over the handshake clearing it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pend_v       <= '0;
            r_pend_val     <= '0;
            r_conflict     <= 1'b0;
            r_conflict_var <= '0;
        end else if (flush_i) begin
            r_pend_v       <= '0;
            r_pend_val     <= '0;
            r_conflict     <= 1'b0;
            r_conflict_var <= '0;
        end else begin
            if (w_can_grant && w_any && w_opp) begin
                r_conflict     <= 1'b1;
                r_conflict_var <= w_sel.vidx;
            end
            for (int i = 1; i <= FORMULA_MAX_VARIABLE; i++) begin
                if (w_write && (w_sel.vidx == VAR_ENC_LEN'(i))) begin
                    r_pend_v[i]   <= 1'b1;
                    r_pend_val[i] <= w_sel.val;
                end else if (w_hs && (r_impl.vidx == VAR_ENC_LEN'(i))) begin
                    r_pend_v[i]   <= 1'b0;
                end
            end
        end
    end

    assign w_conflict     = r_conflict;
    assign conflict_o     = r_conflict;
    assign conflict_var_o = r_conflict_var;
`else
    assign w_dup          = 1'b0;
    assign w_opp          = 1'b0;
    assign w_conflict     = 1'b0;
    assign conflict_o     = 1'b0;
    assign conflict_var_o = '0;
`endif

    // FIFO data arrives the cycle after the read strobe, so FETCH captures it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= IDLE;
            r_impl_valid <= 1'b0;
            r_impl       <= '0;
            r_rr_ptr     <= '0;
        end else if (flush_i) begin
            r_state      <= IDLE;
            r_impl_valid <= 1'b0;
            r_rr_ptr     <= '0;
        end else begin
            if (w_accept) begin
                r_rr_ptr <= (w_idx == PW'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_rd) r_state <= FETCH;
                end
                FETCH: begin
                    if (en_i) begin
                        r_impl       <= impl_t'(fifo_impl_i);
                        r_impl_valid <= 1'b1;
                        r_state      <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (w_hs) begin
                        r_impl_valid <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
